fetch_mem_sequencer: RTL and testbench
======================================

# fetch_mem_sequencer

Sequencer between the multi-cycle stack CPU's control unit and the single-ported 32×8 synchronous memory. Drives all memory control and address lines. Owns the program counter and the instruction register, and arbitrates instruction fetches against push/pop data accesses. The memory has one write and one read port sampled on the rising edge, with registered read data. This block is therefore the only master of that memory.

## Interface
- ADDR_W, 5, memory address width (32 words)
- DATA_W, 8, memory word / instruction width
- RESET_PC, 0, PC value after reset
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- fetch_req  in  1  control unit requests next instruction
- pc_load  in  1  load pc_target into PC (jump/branch)
- pc_target  in  ADDR_W  jump destination
- pc  out  ADDR_W  current PC (address of next fetch)
- ir  out  DATA_W  instruction register; ir[7:5] opcode, ir[4:0] operand address
- ir_valid  out  1  ir holds a fetched, not-yet-superseded instruction
- d_req  in  1  data access request (held until d_ack)
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_ack  out  1  one-cycle pulse, access complete
- d_rdata  out  DATA_W  read data, valid with d_ack
- mem_we, mem_re  out  1  memory write / read enables
- mem_addr  out  ADDR_W  memory address
- mem_wd  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  registered memory read data

## Operation
- States: IDLE, F_ISSUE, F_WAIT, D_ISSUE, D_WAIT.
- Requests are sampled only in IDLE. Priority order: pc_load, then d_req, then fetch_req.
- IDLE → D_ISSUE on d_req. mem_we=d_we, mem_re=!d_we, mem_addr=d_addr and mem_wd=d_wdata are registered.
- D_ISSUE → D_WAIT. The memory performs the access at this edge, and mem_we/mem_re return to 0.
- D_WAIT → IDLE. d_rdata ← mem_rdata on reads; on writes d_rdata holds its previous value. d_ack=1 for exactly one cycle.
- IDLE → F_ISSUE on fetch_req. mem_re=1, mem_addr=pc, ir_valid←0.
- F_ISSUE → F_WAIT.
- F_WAIT → IDLE. ir ← mem_rdata, ir_valid←1, pc ← pc+1 modulo 2^ADDR_W (31 wraps to 0).
- pc_load in any state sets pc←pc_target and ir_valid←0 at the next edge.
  - In F_ISSUE or F_WAIT it aborts the fetch: no ir capture, no increment, next state IDLE.
  - In D_ISSUE or D_WAIT it does not abort the data access.
- The requester keeps d_req high through the ack cycle only if it wants a back-to-back access; a new access is then accepted at that edge.
- All outputs are registered; no combinational path from inputs to outputs.

## Timing
- Reset values: state IDLE, pc=RESET_PC, and ir, ir_valid, d_ack, d_rdata, mem_we, mem_re, mem_addr, mem_wd all 0.
- rst mid-operation abandons any in-flight access immediately, with no ack and no capture.
- Data latency: request sampled at edge e → memory edge e+1 → d_ack high in the cycle after e+2.
- Fetch latency is the same: ir_valid rises after edge e+2.
- Minimum request-to-request spacing is 3 cycles.

## Configuration
- FETCH_PREFETCH_EN defined: adds a one-entry prefetch slot.
  - When in IDLE with no d_req, no fetch_req and the slot empty, the block fetches pc into the slot through the F_ISSUE/F_WAIT path.
  - A later fetch_req with the slot full loads ir from the slot one cycle later, increments pc and empties the slot.
  - pc_load flushes the slot.
  - d_req never preempts a prefetch already issued.
- FETCH_PREFETCH_EN undefined: fetches occur only on fetch_req, with fixed 2-cycle latency.

## Structure
- Package fetch_pkg holds the state enum, ADDR_W/DATA_W defaults, and the opcode field positions OPC_MSB=7, OPC_LSB=5.
- Optional sub-module fetch_pf_slot (valid bit, data register, flush), instantiated only under FETCH_PREFETCH_EN.

## Test plan
- Fetch from reset, mem[0]=8'hA3, fetch_req pulse → ir=8'hA3, ir_valid=1 after 2 edges, pc=1, mem_re high for exactly one cycle with mem_addr=0.
- pc_load pc_target=31, fetch with mem[31]=8'h1F → ir=8'h1F, pc wraps to 0.
- Data write d_addr=5, d_wdata=8'h5C, then read d_addr=5 → d_ack pulse for each, d_rdata=8'h5C, mem_we asserted exactly once.
- d_req and fetch_req raised in the same IDLE cycle → data access completes first (d_ack), fetch starts on the next IDLE edge, ir valid 3 cycles later.
- pc_load=1 with pc_target=12 during F_WAIT → ir unchanged, ir_valid=0, pc=12, state IDLE.
- rst asserted during D_WAIT → all outputs 0 asynchronously, no d_ack; post-reset fetch reads address RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants, FSM encoding and instruction field helpers for the
// fetch/memory sequencer.
package fetch_pkg;

    localparam int FP_ADDR_W = 5;
    localparam int FP_DATA_W = 8;
    localparam int OPC_MSB   = 7;
    localparam int OPC_LSB   = 5;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE    = 3'd0;
    localparam state_t S_F_ISSUE = 3'd1;
    localparam state_t S_F_WAIT  = 3'd2;
    localparam state_t S_D_ISSUE = 3'd3;
    localparam state_t S_D_WAIT  = 3'd4;

    function automatic logic [OPC_MSB-OPC_LSB:0] opcode_of(
        input logic [FP_DATA_W-1:0] instr
    );
        return instr[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/fetch_pf_slot.sv
// One-entry prefetch buffer: valid bit plus data register.
// Flush wins over fill, fill wins over take.
module fetch_pf_slot
    import fetch_pkg::*;
#(
    parameter int DATA_W = FP_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_fill,
    input  logic [DATA_W-1:0] i_fill_data,
    input  logic              i_take,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_fill) begin
            r_valid <= 1'b1;
            r_data  <= i_fill_data;
        end else if (i_take) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/fetch_mem_sequencer.sv
// Sole master of the 32x8 sync memory: owns PC/IR, arbitrates fetch vs data.
// Optional FETCH_PREFETCH_EN adds a one-entry prefetch slot.
module fetch_mem_sequencer
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = FP_ADDR_W,
    parameter int                DATA_W   = FP_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_fetch_req,
    input  logic              i_pc_load,
    input  logic [ADDR_W-1:0] i_pc_target,
    output logic [ADDR_W-1:0] o_pc,
    output logic [DATA_W-1:0] o_ir,
    output logic              o_ir_valid,
    input  logic              i_d_req,
    input  logic              i_d_we,
    input  logic [ADDR_W-1:0] i_d_addr,
    input  logic [DATA_W-1:0] i_d_wdata,
    output logic              o_d_ack,
    output logic [DATA_W-1:0] o_d_rdata,
    output logic              o_mem_we,
    output logic              o_mem_re,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wd,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_d_rdata;
    logic [DATA_W-1:0] r_mem_wd;
    logic              r_ir_valid;
    logic              r_d_ack;
    logic              r_mem_we;
    logic              r_mem_re;
    logic              r_d_we;
    logic              w_idle_free;
    logic              w_fetch_to_ir;

    assign w_idle_free = (r_state == S_IDLE) && !i_pc_load;

`ifdef FETCH_PREFETCH_EN
    logic              r_pf_busy;
    logic              w_pf_valid;
    logic              w_pf_fill;
    logic              w_pf_take;
    logic              w_pf_start;
    logic [DATA_W-1:0] w_pf_data;

    assign w_pf_take  = w_idle_free && !i_d_req && i_fetch_req && w_pf_valid;
    assign w_pf_start = w_idle_free && !i_d_req && !i_fetch_req && !w_pf_valid;
    assign w_pf_fill  = (r_state == S_F_WAIT) && r_pf_busy && !i_pc_load;
    assign w_fetch_to_ir = !i_pc_load && !r_pf_busy;

    fetch_pf_slot #(
        .DATA_W (DATA_W)
    ) u_pf_slot (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_flush     (i_pc_load),
        .i_fill      (w_pf_fill),
        .i_fill_data (i_mem_rdata),
        .i_take      (w_pf_take),
        .o_valid     (w_pf_valid),
        .o_data      (w_pf_data)
    );

    // Marks the in-flight fetch as a prefetch so F_WAIT fills the slot.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pf_busy <= 1'b0;
        end else if (w_pf_start) begin
            r_pf_busy <= 1'b1;
        end else if ((r_state == S_F_WAIT) ||
                     ((r_state == S_F_ISSUE) && i_pc_load)) begin
            r_pf_busy <= 1'b0;
        end
    end
`else
    assign w_fetch_to_ir = !i_pc_load;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_ir       <= '0;
            r_ir_valid <= 1'b0;
            r_d_ack    <= 1'b0;
            r_d_rdata  <= '0;
            r_d_we     <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_re   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_wd   <= '0;
        end else begin
            r_d_ack <= 1'b0;
            if (i_pc_load) begin
                r_pc       <= i_pc_target;
                r_ir_valid <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_idle_free) begin
                        if (i_d_req) begin
                            r_state    <= S_D_ISSUE;
                            r_d_we     <= i_d_we;
                            r_mem_we   <= i_d_we;
                            r_mem_re   <= !i_d_we;
                            r_mem_addr <= i_d_addr;
                            r_mem_wd   <= i_d_wdata;
                        end
`ifdef FETCH_PREFETCH_EN
                        else if (w_pf_take) begin
                            r_ir       <= w_pf_data;
                            r_ir_valid <= 1'b1;
                            r_pc       <= r_pc + 1'b1;
                        end else if (w_pf_start) begin
                            r_state    <= S_F_ISSUE;
                            r_mem_re   <= 1'b1;
                            r_mem_addr <= r_pc;
                        end
`endif
                        else if (i_fetch_req) begin
                            r_state    <= S_F_ISSUE;
                            r_mem_re   <= 1'b1;
                            r_mem_addr <= r_pc;
                            r_ir_valid <= 1'b0;
                        end
                    end
                end
                S_F_ISSUE: begin
                    r_mem_re <= 1'b0;
                    r_state  <= i_pc_load ? S_IDLE : S_F_WAIT;
                end
                S_F_WAIT: begin
                    r_state <= S_IDLE;
                    if (w_fetch_to_ir) begin
                        r_ir       <= i_mem_rdata;
                        r_ir_valid <= 1'b1;
                        r_pc       <= r_pc + 1'b1;
                    end
                end
                S_D_ISSUE: begin
                    r_mem_we <= 1'b0;
                    r_mem_re <= 1'b0;
                    r_state  <= S_D_WAIT;
                end
                S_D_WAIT: begin
                    r_state <= S_IDLE;
                    r_d_ack <= 1'b1;
                    if (!r_d_we) begin
                        r_d_rdata <= i_mem_rdata;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_mem_we <= 1'b0;
                    r_mem_re <= 1'b0;
                end
            endcase
        end
    end

    assign o_pc       = r_pc;
    assign o_ir       = r_ir;
    assign o_ir_valid = r_ir_valid;
    assign o_d_ack    = r_d_ack;
    assign o_d_rdata  = r_d_rdata;
    assign o_mem_we   = r_mem_we;
    assign o_mem_re   = r_mem_re;
    assign o_mem_addr = r_mem_addr;
    assign o_mem_wd   = r_mem_wd;

endmodule

// File: tb/tb_fetch_mem_sequencer.sv
// Self-checking bench for fetch_mem_sequencer (default build) with a
// behavioural 32x8 synchronous memory and expected-value queues.
module tb_fetch_mem_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       fetch_req, pc_load, d_req, d_we;
    logic [4:0] pc_target, d_addr;
    logic [7:0] d_wdata;
    logic [4:0] pc, mem_addr;
    logic [7:0] ir, d_rdata, mem_wd, mem_rdata;
    logic       ir_valid, d_ack, mem_we, mem_re;

    logic [7:0] mem [32];
    logic       bd_we;
    logic [4:0] bd_addr;
    logic [7:0] bd_data;

    logic [7:0] exp_mem [32];
    logic [7:0] rd_q [$];
    logic [7:0] ir_q [$];
    logic [4:0] exp_pc;
    logic [7:0] exp_ir;
    logic [7:0] exp_rdata;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    int re_cnt = 0;
    int ack_cnt = 0;

    always #5 clk = ~clk;

    fetch_mem_sequencer dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_fetch_req (fetch_req),
        .i_pc_load   (pc_load),
        .i_pc_target (pc_target),
        .o_pc        (pc),
        .o_ir        (ir),
        .o_ir_valid  (ir_valid),
        .i_d_req     (d_req),
        .i_d_we      (d_we),
        .i_d_addr    (d_addr),
        .i_d_wdata   (d_wdata),
        .o_d_ack     (d_ack),
        .o_d_rdata   (d_rdata),
        .o_mem_we    (mem_we),
        .o_mem_re    (mem_re),
        .o_mem_addr  (mem_addr),
        .o_mem_wd    (mem_wd),
        .i_mem_rdata (mem_rdata)
    );

    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (mem_we) mem[mem_addr] <= mem_wd;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    always @(negedge clk) begin
        if (mem_we === 1'b1) we_cnt++;
        if (mem_re === 1'b1) re_cnt++;
        if (d_ack === 1'b1) ack_cnt++;
    end

    function automatic logic [7:0] pat(input int i);
        case (i)
            0:       return 8'hA3;
            12:      return 8'hC6;
            31:      return 8'h1F;
            default: return 8'(i) ^ 8'h40;
        endcase
    endfunction

    task automatic wait_ack(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (d_ack !== 1'b1 && n < 8);
    endtask

    task automatic wait_ir(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ir_valid !== 1'b1 && n < 8);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        fetch_req = 0; pc_load = 0; d_req = 0; d_we = 0;
        pc_target = 0; d_addr = 0; d_wdata = 0;
        for (int i = 0; i < 32; i++) begin
            bd_we = 1'b1; bd_addr = 5'(i); bd_data = pat(i);
            exp_mem[i] = pat(i);
            @(negedge clk);
        end
        bd_we = 1'b0;
        checks++; if (pc !== 5'd0) begin errors++; $display("FAIL reset_pc got=%h exp=00", pc); end
        checks++; if (ir !== 8'd0) begin errors++; $display("FAIL reset_ir got=%h exp=00", ir); end
        checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL reset_ir_valid got=%b exp=0", ir_valid); end
        checks++; if (d_ack !== 1'b0 || d_rdata !== 8'd0) begin errors++; $display("FAIL reset_data got ack=%b rdata=%h exp 0/00", d_ack, d_rdata); end
        checks++; if ({mem_we, mem_re} !== 2'b00 || mem_addr !== 5'd0 || mem_wd !== 8'd0) begin errors++; $display("FAIL reset_mem got we=%b re=%b a=%h wd=%h exp zeros", mem_we, mem_re, mem_addr, mem_wd); end
        rst = 1'b0;
        exp_pc = 5'd0; exp_ir = 8'd0; exp_rdata = 8'd0;
        @(negedge clk);
        checks++; if ({mem_we, mem_re, ir_valid} !== 3'b000) begin errors++; $display("FAIL idle_quiet got we=%b re=%b v=%b exp 000", mem_we, mem_re, ir_valid); end
    endtask

    task automatic test_fetch(input string nm);
        int n;
        int re0;
        logic [4:0] fa;
        logic [7:0] e;
        re0 = re_cnt;
        fa = exp_pc;
        fetch_req = 1'b1;
        ir_q.push_back(exp_mem[fa]);
        @(negedge clk);
        fetch_req = 1'b0;
        checks++; if (mem_re !== 1'b1 || mem_addr !== fa || ir_valid !== 1'b0) begin errors++; $display("FAIL %s_issue got re=%b a=%h v=%b exp 1/%h/0", nm, mem_re, mem_addr, ir_valid, fa); end
        wait_ir(n);
        checks++; if (n !== 2) begin errors++; $display("FAIL %s_latency got=%0d exp=2", nm, n); end
        e = ir_q.pop_front();
        exp_ir = e;
        exp_pc = exp_pc + 5'd1;
        checks++; if (ir !== e) begin errors++; $display("FAIL %s_ir got=%h exp=%h", nm, ir, e); end
        checks++; if (pc !== exp_pc) begin errors++; $display("FAIL %s_pc got=%h exp=%h", nm, pc, exp_pc); end
        checks++; if (re_cnt - re0 !== 1) begin errors++; $display("FAIL %s_re_cycles got=%0d exp=1", nm, re_cnt - re0); end
    endtask

    task automatic test_wrap();
        pc_load = 1'b1; pc_target = 5'd31;
        @(negedge clk);
        pc_load = 1'b0;
        exp_pc = 5'd31;
        checks++; if (pc !== 5'd31 || ir_valid !== 1'b0) begin errors++; $display("FAIL wrap_load got pc=%h v=%b exp 1f/0", pc, ir_valid); end
        test_fetch("wrap");
    endtask

    task automatic test_data();
        int n;
        int we0;
        logic [7:0] e;
        we0 = we_cnt;
        d_req = 1'b1; d_we = 1'b1; d_addr = 5'd5; d_wdata = 8'h5C;
        exp_mem[5] = 8'h5C;
        @(negedge clk);
        d_req = 1'b0;
        checks++; if (mem_we !== 1'b1 || mem_re !== 1'b0 || mem_addr !== 5'd5 || mem_wd !== 8'h5C) begin errors++; $display("FAIL wr_issue got we=%b re=%b a=%h wd=%h exp 1/0/05/5c", mem_we, mem_re, mem_addr, mem_wd); end
        wait_ack(n);
        checks++; if (n !== 2) begin errors++; $display("FAIL wr_latency got=%0d exp=2", n); end
        checks++; if (d_rdata !== exp_rdata) begin errors++; $display("FAIL wr_rdata_hold got=%h exp=%h", d_rdata, exp_rdata); end
        @(negedge clk);
        checks++; if (d_ack !== 1'b0) begin errors++; $display("FAIL ack_width got=%b exp=0", d_ack); end
        d_req = 1'b1; d_we = 1'b0; d_addr = 5'd5;
        rd_q.push_back(exp_mem[5]);
        @(negedge clk);
        d_req = 1'b0;
        checks++; if (mem_re !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 5'd5) begin errors++; $display("FAIL rd_issue got re=%b we=%b a=%h exp 1/0/05", mem_re, mem_we, mem_addr); end
        wait_ack(n);
        e = rd_q.pop_front();
        exp_rdata = e;
        checks++; if (n !== 2) begin errors++; $display("FAIL rd_latency got=%0d exp=2", n); end
        checks++; if (d_rdata !== e) begin errors++; $display("FAIL rd_data got=%h exp=%h", d_rdata, e); end
        checks++; if (we_cnt - we0 !== 1) begin errors++; $display("FAIL we_once got=%0d exp=1", we_cnt - we0); end
        checks++; if (mem[5] !== 8'h5C) begin errors++; $display("FAIL mem_write got=%h exp=5c", mem[5]); end
    endtask

    task automatic test_back_to_back();
        int n;
        logic [7:0] e;
        d_req = 1'b1; d_we = 1'b1; d_addr = 5'd7; d_wdata = 8'hAA;
        exp_mem[7] = 8'hAA;
        @(negedge clk);
        checks++; if (mem_we !== 1'b1 || mem_addr !== 5'd7) begin errors++; $display("FAIL b2b_wr got we=%b a=%h exp 1/07", mem_we, mem_addr); end
        wait_ack(n);
        checks++; if (n !== 2) begin errors++; $display("FAIL b2b_wr_latency got=%0d exp=2", n); end
        d_we = 1'b0;
        rd_q.push_back(exp_mem[7]);
        @(negedge clk);
        d_req = 1'b0;
        checks++; if (mem_re !== 1'b1 || mem_addr !== 5'd7 || d_ack !== 1'b0) begin errors++; $display("FAIL b2b_accept got re=%b a=%h ack=%b exp 1/07/0", mem_re, mem_addr, d_ack); end
        wait_ack(n);
        e = rd_q.pop_front();
        exp_rdata = e;
        checks++; if (n !== 2 || d_rdata !== e) begin errors++; $display("FAIL b2b_rd got n=%0d rdata=%h exp 2/%h", n, d_rdata, e); end
    endtask

    task automatic test_priority();
        int n;
        logic [4:0] fa;
        logic [7:0] e;
        fa = exp_pc;
        d_req = 1'b1; d_we = 1'b0; d_addr = 5'd5; fetch_req = 1'b1;
        rd_q.push_back(exp_mem[5]);
        ir_q.push_back(exp_mem[fa]);
        @(negedge clk);
        d_req = 1'b0;
        checks++; if (mem_re !== 1'b1 || mem_addr !== 5'd5) begin errors++; $display("FAIL prio_data_first got re=%b a=%h exp 1/05", mem_re, mem_addr); end
        wait_ack(n);
        e = rd_q.pop_front();
        exp_rdata = e;
        checks++; if (n !== 2 || d_rdata !== e) begin errors++; $display("FAIL prio_ack got n=%0d rdata=%h exp 2/%h", n, d_rdata, e); end
        @(negedge clk);
        fetch_req = 1'b0;
        checks++; if (mem_re !== 1'b1 || mem_addr !== fa || ir_valid !== 1'b0) begin errors++; $display("FAIL prio_fetch_issue got re=%b a=%h v=%b exp 1/%h/0", mem_re, mem_addr, ir_valid, fa); end
        wait_ir(n);
        e = ir_q.pop_front();
        exp_ir = e;
        exp_pc = exp_pc + 5'd1;
        checks++; if (n !== 2 || ir !== e || pc !== exp_pc) begin errors++; $display("FAIL prio_fetch got n=%0d ir=%h pc=%h exp 2/%h/%h", n, ir, pc, e, exp_pc); end
    endtask

    task automatic test_abort();
        fetch_req = 1'b1;
        @(negedge clk);
        fetch_req = 1'b0;
        @(negedge clk);
        pc_load = 1'b1; pc_target = 5'd12;
        @(negedge clk);
        pc_load = 1'b0;
        exp_pc = 5'd12;
        checks++; if (ir !== exp_ir) begin errors++; $display("FAIL abort_ir got=%h exp=%h", ir, exp_ir); end
        checks++; if (ir_valid !== 1'b0 || pc !== 5'd12 || mem_re !== 1'b0) begin errors++; $display("FAIL abort_state got v=%b pc=%h re=%b exp 0/0c/0", ir_valid, pc, mem_re); end
        test_fetch("after_abort");
    endtask

    task automatic test_reset_mid();
        int a0;
        a0 = ack_cnt;
        d_req = 1'b1; d_we = 1'b0; d_addr = 5'd5;
        @(negedge clk);
        d_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (pc !== 5'd0 || ir !== 8'd0 || ir_valid !== 1'b0) begin errors++; $display("FAIL async_rst_cpu got pc=%h ir=%h v=%b exp zeros", pc, ir, ir_valid); end
        checks++; if (d_ack !== 1'b0 || d_rdata !== 8'd0 || mem_re !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 5'd0 || mem_wd !== 8'd0) begin errors++; $display("FAIL async_rst_mem got ack=%b rd=%h re=%b we=%b a=%h wd=%h exp zeros", d_ack, d_rdata, mem_re, mem_we, mem_addr, mem_wd); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_pc = 5'd0; exp_rdata = 8'd0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (ack_cnt !== a0) begin errors++; $display("FAIL rst_no_ack got=%0d exp=%0d", ack_cnt - a0, 0); end
        test_fetch("post_reset");
    endtask

    initial begin
        bd_we = 1'b0; bd_addr = 5'd0; bd_data = 8'd0;
        test_reset();
        test_fetch("fetch0");
        test_wrap();
        test_data();
        test_back_to_back();
        test_priority();
        test_abort();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
